// File: rtl/reqack_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reqack_arbiter
//  Description : Round-robin sharing of one req/ack/done resource among N_REQ
//                clients. Issues a single request pulse per grant, checks the
//                ack window and the ack-then-done sequence, and reports
//                per-client completion/error plus an interrupt pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module reqack_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_ACK = 5,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] cli_req,
  output logic [N_REQ-1:0] cli_gnt,
  output logic [N_REQ-1:0] cli_done,
  output logic [N_REQ-1:0] cli_err,
  output logic             res_req,
  input  logic             res_ack,
  input  logic             res_done,
  output logic             intrpt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_ACK + 1);
  localparam logic [IDX_W:0]   N_EXT   = (IDX_W + 1)'(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ACK);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CMPL      = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             res_req_q, res_req_d;
  logic             intrpt_q, intrpt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W:0]   arb_sum;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin pick: first requesting client above last_grant, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      arb_sum = {1'b0, last_q} + (IDX_W + 1)'(i);
      if (arb_sum >= N_EXT) arb_sum = arb_sum - N_EXT;
      if (!arb_found && cli_req[arb_sum[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_sum[IDX_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic; pulse outputs default low.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    res_req_d = 1'b0;
    intrpt_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d   = S_REQ;
          win_d     = arb_idx;
          gnt_d     = onehot(arb_idx);
          res_req_d = 1'b1;
          cnt_d     = '0;
        end
      end
      S_REQ: begin
        // Ack seen in the request cycle itself is deliberately ignored.
        state_d = S_WAIT_ACK;
        cnt_d   = CNT_W'(1);
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (res_ack) begin
          // Ack wins over a simultaneous done; done must still follow.
          state_d = S_WAIT_DONE;
        end else if (res_done || (cnt_q == CNT_MAX)) begin
          state_d = S_ERR;
        end
      end
      S_WAIT_DONE: begin
        if (res_done && !res_ack) state_d = S_CMPL;
        else                      state_d = S_ERR;
      end
      S_CMPL, S_ERR: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    // Transaction end: pulse the owner and remember it for fairness.
    if (state_d == S_CMPL) begin
      done_d   = onehot(win_q);
      intrpt_d = 1'b1;
      last_d   = win_q;
    end
    if (state_d == S_ERR) begin
      err_d    = onehot(win_q);
      intrpt_d = 1'b1;
      last_d   = win_q;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      res_req_q <= 1'b0;
      intrpt_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      res_req_q <= res_req_d;
      intrpt_q  <= intrpt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cli_gnt  = gnt_q;
  assign cli_done = done_q;
  assign cli_err  = err_q;
  assign res_req  = res_req_q;
  assign intrpt   = intrpt_q;
  assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reqack_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reqack_arbiter
//  Description : Directed self-checking bench for reqack_arbiter. A second
//                instance with a 2-bit error counter shares the stimulus to
//                observe saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reqack_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] cli_req;
  logic       res_ack;
  logic       res_done;

  logic [3:0] cli_gnt, cli_done, cli_err;
  logic       res_req, intrpt;
  logic [7:0] err_cnt;

  logic [3:0] s_gnt, s_done, s_err;
  logic       s_req, s_intrpt;
  logic [1:0] s_err_cnt;

  typedef struct {
    int cli;
    bit ok;
    int lat;
    int err;
    int sat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_err = 0;
  int   exp_sat = 0;

  reqack_arbiter #(.N_REQ(4), .MAX_ACK(5), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .cli_req(cli_req),
    .cli_gnt(cli_gnt), .cli_done(cli_done), .cli_err(cli_err),
    .res_req(res_req), .res_ack(res_ack), .res_done(res_done),
    .intrpt(intrpt), .err_cnt(err_cnt)
  );

  reqack_arbiter #(.N_REQ(4), .MAX_ACK(5), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .cli_req(cli_req),
    .cli_gnt(s_gnt), .cli_done(s_done), .cli_err(s_err),
    .res_req(s_req), .res_ack(res_ack), .res_done(res_done),
    .intrpt(s_intrpt), .err_cnt(s_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: ack_m/done_m bit k drives the resource k cycles after res_req.
  task automatic run_txn(input string tag, input logic [3:0] req,
                         input logic [15:0] ack_m, input logic [15:0] done_m,
                         input int exp_cli, input bit exp_ok, input int exp_lat,
                         input int exp_wait);
    int   n;
    int   lat;
    bit   seen;
    exp_t e;
    logic [3:0] kk;
    logic [31:0] one;
    cli_req = req;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (res_req) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check({tag, "_req_seen"}, 32'd0, 32'd1);
      return;
    end
    if (exp_wait > 0) check({tag, "_turnaround"}, n, exp_wait);
    one = 32'd1 << exp_cli;
    check({tag, "_gnt"}, {28'd0, cli_gnt}, one);
    check({tag, "_sat_gnt"}, {28'd0, s_gnt}, one);
    if (!exp_ok) begin
      exp_err++;
      if (exp_sat < 3) exp_sat++;
    end
    e.cli = exp_cli; e.ok = exp_ok; e.lat = exp_lat; e.err = exp_err; e.sat = exp_sat;
    sb.push_back(e);

    lat = 0;
    for (int k = 0; k < 12; k++) begin
      kk = k[3:0];
      res_ack  = ack_m[kk];
      res_done = done_m[kk];
      @(negedge clk);
      if (k == 0) check({tag, "_req_single_pulse"}, {31'd0, res_req}, 32'd0);
      if (intrpt) begin
        lat = k + 1;
        break;
      end
    end
    res_ack  = 1'b0;
    res_done = 1'b0;

    e = sb.pop_front();
    check({tag, "_intrpt_lat"}, lat, e.lat);
    check({tag, "_done"}, {28'd0, cli_done}, e.ok ? (32'd1 << e.cli) : 32'd0);
    check({tag, "_err"}, {28'd0, cli_err}, e.ok ? 32'd0 : (32'd1 << e.cli));
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, e.err);
    check({tag, "_sat_err_cnt"}, {30'd0, s_err_cnt}, e.sat);
    check({tag, "_sat_intrpt"}, {31'd0, s_intrpt}, 32'd1);
  endtask

  initial begin
    bit bad;
    reset    = 1'b1;
    cli_req  = '0;
    res_ack  = 1'b0;
    res_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", {28'd0, cli_gnt}, 32'd0);
    check("rst_pulses", {24'd0, cli_done, cli_err}, 32'd0);
    check("rst_req_intrpt", {30'd0, res_req, intrpt}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    reset = 1'b0;

    // Round robin from reset: client 0 first, then 1,2,3,0.
    run_txn("rr0", 4'b1111, 16'h0002, 16'h0004, 0, 1'b1, 3, 1);
    run_txn("rr1", 4'b1111, 16'h0002, 16'h0004, 1, 1'b1, 3, 2);
    run_txn("rr2", 4'b1111, 16'h0002, 16'h0004, 2, 1'b1, 3, 2);
    run_txn("rr3", 4'b1111, 16'h0002, 16'h0004, 3, 1'b1, 3, 2);
    run_txn("rr4", 4'b1111, 16'h0002, 16'h0004, 0, 1'b1, 3, 2);

    // Single client, ack at 2, done at 3.
    run_txn("single", 4'b0001, 16'h0004, 16'h0008, 0, 1'b1, 4, 0);
    // Ack window edges.
    run_txn("ack_at_max", 4'b0001, 16'h0020, 16'h0040, 0, 1'b1, 7, 0);
    run_txn("no_ack", 4'b0001, 16'h0000, 16'h0000, 0, 1'b0, 6, 0);
    run_txn("ack_in_req", 4'b0001, 16'h0001, 16'h0000, 0, 1'b0, 6, 0);
    // Done protocol violations.
    run_txn("ack_no_done", 4'b0001, 16'h0002, 16'h0000, 0, 1'b0, 3, 0);
    run_txn("ack_with_done", 4'b0001, 16'h0006, 16'h0004, 0, 1'b0, 3, 0);
    run_txn("done_no_ack", 4'b0001, 16'h0000, 16'h0004, 0, 1'b0, 3, 0);
    // Ack and done together count as ack; done follows -> success.
    run_txn("ack_done_same", 4'b0001, 16'h0002, 16'h0006, 0, 1'b1, 3, 0);

    // Resource strobes while idle are ignored.
    cli_req  = '0;
    res_ack  = 1'b1;
    res_done = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (intrpt || res_req) bad = 1'b1;
    end
    res_ack  = 1'b0;
    res_done = 1'b0;
    check("idle_strobe_quiet", {31'd0, bad}, 32'd0);
    check("idle_strobe_err_cnt", {24'd0, err_cnt}, 32'd5);

    // Reset in WAIT_ACK.
    cli_req = 4'b0001;
    bad = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_req) begin
        bad = 1'b0;
        break;
      end
    end
    check("midrst_req_seen", {31'd0, bad}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_gnt", {28'd0, cli_gnt}, 32'd0);
    check("midrst_pulses", {24'd0, cli_done, cli_err}, 32'd0);
    check("midrst_req_intrpt", {30'd0, res_req, intrpt}, 32'd0);
    check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("midrst_sat_err_cnt", {30'd0, s_err_cnt}, 32'd0);
    cli_req = '0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (intrpt || (|cli_done) || (|cli_err)) bad = 1'b1;
    end
    check("midrst_no_intrpt", {31'd0, bad}, 32'd0);
    reset   = 1'b0;
    exp_err = 0;
    exp_sat = 0;
    run_txn("post_rst", 4'b1010, 16'h0002, 16'h0004, 1, 1'b1, 3, 0);

    // Five timeouts: wide counter reaches 5, 2-bit counter holds at 3.
    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("sat%0d", i), 4'b0100, 16'h0000, 16'h0000, 2, 1'b0, 6, 0);
    end
    cli_req = '0;
    @(negedge clk);
    check("final_err_cnt", {24'd0, err_cnt}, 32'd5);
    check("final_sat_err_cnt", {30'd0, s_err_cnt}, 32'd3);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
